mask_row_sequencer: RTL and testbench
=====================================

// Module: mask_row_sequencer
// PURPOSE
//  Per-frame scheduler between the three row-mask sources and the mask generator (MG):
//  - sources: repeat-pattern, sliding-pattern, random-mask.
//  - On frame_start, latches the mask type and sensor height, then forwards exactly
//    image_sensor_h rows from the selected source to MG through a one-entry output register.
//  - Pulses frame_done when the last row has been taken by MG.
// PARAMETERS
//  ROW_W  32  width of one row mask in bits.
//  H_W    11  width of the row counter and height input (covers 1080).
// PORTS
//  clk             in   1      clock.
//  rst_n           in   1      asynchronous reset, active low.
//  clk_en          in   1      clock enable; all state frozen when low.
//  mask_type       in   2      00 repeat, 01 sliding, 10 random, 11 illegal.
//  image_sensor_h  in   H_W    rows per frame.
//  frame_start     in   1      start request, sampled in IDLE only.
//  frame_abort     in   1      abort the current frame.
//  src_valid       in   3      [0] repeat, [1] sliding, [2] random: row available.
//  rp_row          in   ROW_W  repeat-pattern row.
//  sp_row          in   ROW_W  sliding-pattern row.
//  rm_row          in   ROW_W  random-mask row.
//  src_ready       out  3      one-hot ready to the selected source.
//  mg_valid        out  1      row valid to MG.
//  mg_row          out  ROW_W  row to MG.
//  mg_row_idx      out  H_W    index of the row on mg_row.
//  mg_ready        in   1      MG accepts the row.
//  busy            out  1      high when state is not IDLE.
//  frame_done      out  1      one-cycle pulse at the end of a frame.
//  err_bad_type    out  1      sticky; cleared by reset only.
// BEHAVIOUR
//  Reset: IDLE; outputs mg_valid/mg_row/mg_row_idx/src_ready/busy/frame_done/err_bad_type = 0.
//  Transfers and state updates occur only on cycles with clk_en=1.
//  src_ready is forced to 0 when clk_en=0.
//  FSM states: IDLE, RUN, FLUSH, DONE.
//  - IDLE, frame_start=1:
//    - mask_type=11: set err_bad_type; stay IDLE.
//    - image_sensor_h=0: go to DONE.
//    - Otherwise: latch sel=mask_type and h=image_sensor_h; clear cnt; go to RUN.
//  - RUN:
//    - src_ready[sel] = ~mg_valid | mg_ready; the other two bits are 0.
//    - Accept when src_valid[sel] & src_ready[sel]: mg_row <= row, mg_row_idx <= cnt,
//      mg_valid <= 1, cnt++.
//    - Accepting row h-1 moves the FSM to FLUSH.
//  - FLUSH: src_ready = 0; when mg_valid & mg_ready, mg_valid <= 0 and go to DONE.
//  - DONE: frame_done = 1 for one cycle; go to IDLE.
//  Output register:
//    - mg_valid drops after an MG take with no new accept in the same cycle.
//    - Take and accept in the same cycle give back-to-back rows, 1 row/cycle.
//    - Latency from source accept to mg_valid is 1 cycle.
//    - mg_row and mg_row_idx hold stable while mg_valid=1 and mg_ready=0.
//  Arithmetic: cnt is H_W bits unsigned; compare cnt == h-1 on h latched at start.
//    No wrap occurs because h is at most 2^H_W-1.
//  Boundaries:
//  - frame_start outside IDLE is ignored.
//  - mask_type and image_sensor_h changes mid-frame are ignored (latched values are used).
//  - frame_abort, any state: IDLE on the next enabled cycle; mg_valid cleared;
//    no frame_done. Abort has priority over frame_start and over any accept in the same cycle.
//  - h=1: one row is accepted, then FLUSH.
//  - src_valid on non-selected bits is ignored.
// CONFIGURATION
//  MASK_SEQ_CHECKSUM_EN defined:
//  - Adds output frame_checksum [ROW_W]: XOR of all rows accepted in the frame.
//  - Cleared on the start accept; stable from the frame_done cycle until the next start.
//  - Reset value 0; abort clears it to 0.
//  Undefined: port and logic are absent; all other behaviour is identical.
// TESTING
//  1. mask_type=00, h=4, src_valid[0]=1, mg_ready=1 ->
//     4 rows on consecutive cycles, idx 0..3, then frame_done 1 cycle after FLUSH take.
//  2. mask_type=01, h=3, mg_ready toggling 1010 ->
//     mg_row held stable while stalled; src_ready[1] low only when mg_valid & ~mg_ready.
//  3. mask_type=11 with frame_start -> err_bad_type=1, busy=0, no src_ready.
//     image_sensor_h=0 -> frame_done after 1 cycle, no mg_valid.
//  4. frame_abort at row 2 of h=8 -> next cycle IDLE, mg_valid=0, no frame_done;
//     a new frame_start then restarts from idx 0.
//  5. clk_en=0 for 5 cycles mid-RUN with src_valid=1 ->
//     no accepts, cnt/mg_row frozen; resumes exactly where it stopped.
//  6. CHECKSUM_EN, rows 0xFFFF0000, 0x0000FFFF, 0x12345678 -> frame_checksum=0xEDCBA987 at frame_done.

Source files
------------

// File: rtl/mask_row_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mask_row_sequencer
//  Purpose  : Per-frame row scheduler from repeat/sliding/random mask sources
//             to the mask generator through a one-entry output register.
//  Options  : MASK_SEQ_CHECKSUM_EN adds frame_checksum (XOR of frame rows).
//  Revision : 1.0 - initial release
// ============================================================================
module mask_row_sequencer #(
  parameter int ROW_W = 32,
  parameter int H_W   = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic [1:0]       mask_type,
  input  logic [H_W-1:0]   image_sensor_h,
  input  logic             frame_start,
  input  logic             frame_abort,
  input  logic [2:0]       src_valid,
  input  logic [ROW_W-1:0] rp_row,
  input  logic [ROW_W-1:0] sp_row,
  input  logic [ROW_W-1:0] rm_row,
  output logic [2:0]       src_ready,
  output logic             mg_valid,
  output logic [ROW_W-1:0] mg_row,
  output logic [H_W-1:0]   mg_row_idx,
  input  logic             mg_ready,
  output logic             busy,
  output logic             frame_done,
`ifdef MASK_SEQ_CHECKSUM_EN
  output logic [ROW_W-1:0] frame_checksum,
`endif
  output logic             err_bad_type
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [1:0]       r_sel;
  logic [H_W-1:0]   r_h;
  logic [H_W-1:0]   r_cnt;

  logic             w_can_load;
  logic             w_take;
  logic             w_accept;
  logic             w_last;
  logic             w_start_ok;
  logic [ROW_W-1:0] w_sel_row;

  assign w_can_load = ~mg_valid | mg_ready;
  assign w_take     = mg_valid & mg_ready;
  assign w_last     = (r_cnt == (r_h - H_W'(1)));
  assign w_start_ok = (r_state == S_IDLE) & frame_start & (mask_type != 2'b11);
  assign busy       = (r_state != S_IDLE);
  assign frame_done = (r_state == S_DONE);

  // Ready is withheld during an abort so no source row is lost to a dropped accept.
  always_comb begin
    src_ready = 3'b000;
    if (clk_en && !frame_abort && (r_state == S_RUN) && w_can_load) begin
      case (r_sel)
        2'd0:    src_ready = 3'b001;
        2'd1:    src_ready = 3'b010;
        2'd2:    src_ready = 3'b100;
        default: src_ready = 3'b000;
      endcase
    end
  end

  always_comb begin
    case (r_sel)
      2'd0:    w_sel_row = rp_row;
      2'd1:    w_sel_row = sp_row;
      default: w_sel_row = rm_row;
    endcase
  end

  assign w_accept = |(src_valid & src_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_sel        <= 2'd0;
      r_h          <= '0;
      r_cnt        <= '0;
      mg_valid     <= 1'b0;
      mg_row       <= '0;
      mg_row_idx   <= '0;
      err_bad_type <= 1'b0;
    end else if (clk_en) begin
      if (frame_abort) begin
        r_state  <= S_IDLE;
        mg_valid <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (frame_start) begin
              if (mask_type == 2'b11) begin
                err_bad_type <= 1'b1;
              end else if (image_sensor_h == '0) begin
                r_state <= S_DONE;
              end else begin
                r_sel   <= mask_type;
                r_h     <= image_sensor_h;
                r_cnt   <= '0;
                r_state <= S_RUN;
              end
            end
          end
          S_RUN: begin
            if (w_accept) begin
              mg_row     <= w_sel_row;
              mg_row_idx <= r_cnt;
              mg_valid   <= 1'b1;
              r_cnt      <= r_cnt + H_W'(1);
              if (w_last) begin
                r_state <= S_FLUSH;
              end
            end else if (w_take) begin
              mg_valid <= 1'b0;
            end
          end
          S_FLUSH: begin
            if (w_take) begin
              mg_valid <= 1'b0;
              r_state  <= S_DONE;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

`ifdef MASK_SEQ_CHECKSUM_EN
  logic [ROW_W-1:0] r_checksum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_checksum <= '0;
    end else if (clk_en) begin
      if (frame_abort || w_start_ok) begin
        r_checksum <= '0;
      end else if (w_accept) begin
        r_checksum <= r_checksum ^ w_sel_row;
      end
    end
  end

  assign frame_checksum = r_checksum;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mask_row_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mask_row_sequencer
//  Purpose  : Scoreboard bench for mask_row_sequencer (directed frames).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mask_row_sequencer;
  localparam int ROW_W = 32;
  localparam int H_W   = 11;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clk_en = 1'b0;
  logic [1:0]       mask_type = 2'b00;
  logic [H_W-1:0]   image_sensor_h = '0;
  logic             frame_start = 1'b0;
  logic             frame_abort = 1'b0;
  logic [2:0]       src_valid = 3'b000;
  logic [ROW_W-1:0] rp_row, sp_row, rm_row;
  logic [2:0]       src_ready;
  logic             mg_valid;
  logic [ROW_W-1:0] mg_row;
  logic [H_W-1:0]   mg_row_idx;
  logic             mg_ready = 1'b0;
  logic             busy;
  logic             frame_done;
  logic             err_bad_type;
`ifdef MASK_SEQ_CHECKSUM_EN
  logic [ROW_W-1:0] frame_checksum;
`endif

  mask_row_sequencer #(.ROW_W(ROW_W), .H_W(H_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .clk_en         (clk_en),
    .mask_type      (mask_type),
    .image_sensor_h (image_sensor_h),
    .frame_start    (frame_start),
    .frame_abort    (frame_abort),
    .src_valid      (src_valid),
    .rp_row         (rp_row),
    .sp_row         (sp_row),
    .rm_row         (rm_row),
    .src_ready      (src_ready),
    .mg_valid       (mg_valid),
    .mg_row         (mg_row),
    .mg_row_idx     (mg_row_idx),
    .mg_ready       (mg_ready),
    .busy           (busy),
    .frame_done     (frame_done),
`ifdef MASK_SEQ_CHECKSUM_EN
    .frame_checksum (frame_checksum),
`endif
    .err_bad_type   (err_bad_type)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [H_W-1:0]   idx;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  // Source row contents: distinct per source; random source carries the checksum vectors.
  function automatic logic [ROW_W-1:0] rowfn(input logic [1:0] t, input int i);
    logic [ROW_W-1:0] r;
    case (t)
      2'd0:    r = 32'hA500_0000 + i;
      2'd1:    r = 32'h5A00_0000 + (i * 3);
      default: begin
        case (i)
          0:       r = 32'hFFFF_0000;
          1:       r = 32'h0000_FFFF;
          2:       r = 32'h1234_5678;
          default: r = 32'hC300_0000 ^ i;
        endcase
      end
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Source model: each source steps to its next row after a handshake.
  logic [H_W-1:0] ptr = '0;
  logic           src_clr = 1'b0;
  logic           take_n = 1'b0;
  assign rp_row = rowfn(2'd0, int'(ptr));
  assign sp_row = rowfn(2'd1, int'(ptr));
  assign rm_row = rowfn(2'd2, int'(ptr));

  always @(negedge clk) take_n <= |(src_valid & src_ready);
  always @(posedge clk) begin
    if (src_clr)     ptr <= '0;
    else if (take_n) ptr <= ptr + H_W'(1);
  end

  // Monitor: pops the scoreboard on every MG take and checks the output register rules.
  logic             stall_prev = 1'b0;
  logic [ROW_W-1:0] row_prev = '0;
  logic [H_W-1:0]   idx_prev = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev) begin
        chk("hold_valid", 64'(mg_valid), 64'd1);
        chk("hold_row", 64'(mg_row), 64'(row_prev));
        chk("hold_idx", 64'(mg_row_idx), 64'(idx_prev));
      end
      if (clk_en && mg_valid && mg_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_row: got idx %0d row %0h expected no row", mg_row_idx, mg_row);
        end else begin
          mon_e = exp_q.pop_front();
          chk("row", 64'(mg_row), 64'(mon_e.row));
          chk("row_idx", 64'(mg_row_idx), 64'(mon_e.idx));
        end
      end
      if ((mg_valid && !mg_ready) || !clk_en)
        chk("src_ready_gated", 64'(src_ready), 64'd0);
      if (clk_en && frame_done) begin
        done_cnt <= done_cnt + 1;
        chk("done_no_valid", 64'(mg_valid), 64'd0);
      end
      stall_prev <= mg_valid && !mg_ready && !frame_abort;
      row_prev   <= mg_row;
      idx_prev   <= mg_row_idx;
    end
  end

  task automatic start_frame(input logic [1:0] t, input int h, input int npush);
    exp_t e;
    for (int i = 0; i < npush; i++) begin
      e.row = rowfn(t, i);
      e.idx = H_W'(i);
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    mask_type = t; image_sensor_h = H_W'(h); frame_start = 1'b1; src_clr = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0; src_clr = 1'b0;
    // Mid-frame input changes must be ignored.
    mask_type = 2'b11; image_sensor_h = H_W'(5);
  endtask

  task automatic wait_done(input string name, input int max_cyc, output int n);
    logic seen;
    seen = 1'b0;
    n = 0;
    for (int c = 1; c <= max_cyc && !seen; c++) begin
      @(negedge clk);
      if (frame_done) begin
        seen = 1'b1;
        n = c;
      end
    end
    chk(name, 64'(seen), 64'd1);
  endtask

  int n;
  logic t2_seen;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mg_valid", 64'(mg_valid), 64'd0);
    chk("rst_mg_row", 64'(mg_row), 64'd0);
    chk("rst_mg_idx", 64'(mg_row_idx), 64'd0);
    chk("rst_src_ready", 64'(src_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_err", 64'(err_bad_type), 64'd0);
`ifdef MASK_SEQ_CHECKSUM_EN
    chk("rst_checksum", 64'(frame_checksum), 64'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1; clk_en = 1'b1;

    // Repeat source, full rate
    mg_ready = 1'b1; src_valid = 3'b001;
    start_frame(2'd0, 4, 4);
    wait_done("t1_done", 30, n);
    chk("t1_latency", 64'(n), 64'd6);
    chk("t1_rows_left", 64'(exp_q.size()), 64'd0);

    // Sliding source with MG stalling every other cycle; non-selected valids set
    src_valid = 3'b111;
    start_frame(2'd1, 3, 3);
    t2_seen = 1'b0;
    for (int c = 0; c < 40 && !t2_seen; c++) begin
      @(negedge clk);
      if (frame_done) t2_seen = 1'b1;
      @(posedge clk); #1;
      mg_ready = ~mg_ready;
    end
    chk("t2_done", 64'(t2_seen), 64'd1);
    chk("t2_rows_left", 64'(exp_q.size()), 64'd0);
    mg_ready = 1'b1;

    // Illegal type, then zero-height frame
    @(posedge clk); #1;
    mask_type = 2'b11; image_sensor_h = H_W'(4); frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    @(negedge clk);
    chk("t3_err", 64'(err_bad_type), 64'd1);
    chk("t3_busy", 64'(busy), 64'd0);
    chk("t3_src_ready", 64'(src_ready), 64'd0);
    start_frame(2'd0, 0, 0);
    wait_done("t3_h0_done", 5, n);
    chk("t3_h0_latency", 64'(n), 64'd1);
    chk("t3_h0_valid", 64'(mg_valid), 64'd0);

    // Abort with row 2 in the output register
    src_valid = 3'b001; mg_ready = 1'b1;
    start_frame(2'd0, 8, 2);
    repeat (3) @(posedge clk);
    #1;
    frame_abort = 1'b1; mg_ready = 1'b0;
    @(posedge clk); #1;
    frame_abort = 1'b0;
    @(negedge clk);
    chk("t4_busy", 64'(busy), 64'd0);
    chk("t4_valid", 64'(mg_valid), 64'd0);
    chk("t4_rows_left", 64'(exp_q.size()), 64'd0);
    repeat (5) @(negedge clk);
    chk("t4_no_done", 64'(done_cnt), 64'd3);
    mg_ready = 1'b1;
    start_frame(2'd0, 2, 2);
    wait_done("t4_restart_done", 20, n);

    // Clock-enable freeze mid-frame
    src_valid = 3'b010;
    start_frame(2'd1, 6, 6);
    repeat (2) @(posedge clk);
    #1;
    clk_en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t5_frozen_idx", 64'(mg_row_idx), 64'd1);
      chk("t5_frozen_busy", 64'(busy), 64'd1);
    end
    @(posedge clk); #1;
    clk_en = 1'b1;
    wait_done("t5_done", 30, n);
    chk("t5_rows_left", 64'(exp_q.size()), 64'd0);

    // Random source, checksum vectors
    src_valid = 3'b100;
    start_frame(2'd2, 3, 3);
    wait_done("t6_done", 20, n);
`ifdef MASK_SEQ_CHECKSUM_EN
    chk("t6_checksum", 64'(frame_checksum), 64'hEDCB_A987);
    repeat (3) @(negedge clk);
    chk("t6_checksum_hold", 64'(frame_checksum), 64'hEDCB_A987);
`endif
    chk("t6_rows_left", 64'(exp_q.size()), 64'd0);

    repeat (3) @(negedge clk);
    chk("total_frames", 64'(done_cnt), 64'd6);
    chk("final_err", 64'(err_bad_type), 64'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
